// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
//   - key code constants as delivered by the keypad decoder
//   - ALU operation encodings driven on alu_op
//   - sequencer state enumeration
//   - small key-classification helpers
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_OP = 3'd1,
        ST_ENTER_B  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT     = 3'd4,
        ST_SHOW     = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// calc_digit_acc: one decimal operand register with its digit count.
//   clk, reset   : clock, asynchronous active-high reset
//   clr          : zero value and count (combined with load_digit the
//                  register restarts holding just that digit)
//   load_digit   : shift a new decimal digit in (value*10 + digit)
//   digit        : 0..9
//   value        : binary operand value
//   full         : MAX_DIGITS digits held; further digits are dropped
module calc_digit_acc #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load_digit,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic        full
);

    localparam int CW = $clog2(MAX_DIGITS + 1) + 1;

    logic [15:0]   value_q, value_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   prod;

    // 20-bit multiply-accumulate, truncated to 16 bits on load
    assign prod = ({4'd0, value_q} * 20'd10) + {16'd0, digit};
    assign full = (cnt_q >= CW'(MAX_DIGITS));

    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr) begin
            value_d = '0;
            cnt_d   = '0;
            if (load_digit) begin
                value_d = {12'd0, digit};
                cnt_d   = CW'(1);
            end
        end else if (load_digit && !full) begin
            value_d = prod[15:0];
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM of the keypad calculator.
// Accumulates operands A and B from key codes, latches the operator,
// launches the ALU with a one-cycle alu_start and waits (bounded by
// ALU_TIMEOUT) for alu_done, then presents result or error to the display.
//   clk, reset            : clock, asynchronous active-high reset
//   enable                : low drops keys; WAIT keeps running
//   key_valid, key_code   : key strobe and code (0-9, A/B/C op, E eq, F clr)
//   alu_a, alu_b, alu_op  : operands and operation to the ALU
//   alu_start             : one-cycle launch pulse (EXEC state)
//   alu_done, alu_result,
//   alu_ovf               : ALU completion strobe, result, overflow
//   disp_value, disp_err  : display value and error flag
//   busy                  : high in EXEC and WAIT
// Build option: CALC_SEQ_CHAIN_EN lets an operator in SHOW continue
// from the previous result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_ovf,
    output logic [15:0] disp_value,
    output logic        disp_err,
    output logic        busy
);

    localparam int TW = $clog2(ALU_TIMEOUT) + 1;

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   res_q, res_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // A is taken from the latched result after an operator chain
    logic          chain_q, chain_d;

    logic          a_clr, a_ld, b_clr, b_ld;
    logic [15:0]   a_val, b_val;
    logic          a_full, b_full;
    logic          key_acc, k_clr, k_dig, k_op, k_eq;

    assign key_acc = key_valid && enable;
    assign k_clr   = key_acc && (key_code == KEY_CLR);
    assign k_dig   = key_acc && is_digit(key_code);
    assign k_op    = key_acc && is_op(key_code);
    assign k_eq    = key_acc && (key_code == KEY_EQ);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        chain_d = chain_q;
        a_clr   = 1'b0;
        a_ld    = 1'b0;
        b_clr   = 1'b0;
        b_ld    = 1'b0;
        if (k_clr) begin
            // clear beats everything, including a same-edge alu_done
            state_d = ST_ENTER_A;
            op_d    = OP_ADD;
            chain_d = 1'b0;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (k_dig) begin
                        a_ld = !a_full;
                    end else if (k_op) begin
                        op_d    = key_to_op(key_code);
                        state_d = ST_ENTER_OP;
                    end
                end
                ST_ENTER_OP: begin
                    if (k_op) begin
                        op_d = key_to_op(key_code);
                    end else if (k_dig) begin
                        b_clr   = 1'b1;
                        b_ld    = 1'b1;
                        state_d = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (k_dig) begin
                        b_ld = !b_full;
                    end else if (k_eq) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        if (alu_ovf) begin
                            state_d = ST_ERROR;
                        end else begin
                            res_d   = alu_result;
                            state_d = ST_SHOW;
                        end
                    end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (k_dig) begin
                        a_clr   = 1'b1;
                        a_ld    = 1'b1;
                        b_clr   = 1'b1;
                        chain_d = 1'b0;
                        state_d = ST_ENTER_A;
                    end
`ifdef CALC_SEQ_CHAIN_EN
                    else if (k_op) begin
                        a_clr   = 1'b1;
                        b_clr   = 1'b1;
                        chain_d = 1'b1;
                        op_d    = key_to_op(key_code);
                        state_d = ST_ENTER_OP;
                    end
`endif
                end
                ST_ERROR: ;
                default: state_d = ST_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ENTER_A;
            op_q    <= OP_ADD;
            res_q   <= '0;
            tmo_q   <= '0;
            chain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            chain_q <= chain_d;
        end
    end

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk        (clk),
        .reset      (reset),
        .clr        (a_clr),
        .load_digit (a_ld),
        .digit      (key_code),
        .value      (a_val),
        .full       (a_full)
    );

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk        (clk),
        .reset      (reset),
        .clr        (b_clr),
        .load_digit (b_ld),
        .digit      (key_code),
        .value      (b_val),
        .full       (b_full)
    );

    assign alu_a     = chain_q ? res_q : a_val;
    assign alu_b     = b_val;
    assign alu_op    = op_q;
    assign alu_start = (state_q == ST_EXEC);
    assign busy      = (state_q == ST_EXEC) || (state_q == ST_WAIT);
    assign disp_err  = (state_q == ST_ERROR);

    always_comb begin
        case (state_q)
            ST_ENTER_B: disp_value = alu_b;
            ST_SHOW:    disp_value = res_q;
            ST_ERROR:   disp_value = '0;
            default:    disp_value = alu_a;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int MAXD = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        alu_ovf = 1'b0;
    logic [15:0] disp_value;
    logic        disp_err;
    logic        busy;

    always #5 clk = ~clk;

    calc_sequencer #(.MAX_DIGITS(MAXD), .ALU_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .disp_value (disp_value),
        .disp_err   (disp_err),
        .busy       (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] res;
    } txn_t;

    txn_t        sb[$];
    txn_t        nt, et;
    int          checks = 0;
    int          errors = 0;
    bit          seen;
    logic [15:0] ca, cb;
    logic [1:0]  cop;
    int          n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // bounded monitor: stops in the cycle where alu_start is high
    task automatic wait_start();
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (alu_start) begin
                seen = 1'b1;
                ca   = alu_a;
                cb   = alu_b;
                cop  = alu_op;
            end else begin
                tick();
            end
        end
    endtask

    task automatic pulse_done(input logic [15:0] r, input logic ovf);
        alu_done   = 1'b1;
        alu_result = r;
        alu_ovf    = ovf;
        tick();
        alu_done   = 1'b0;
        alu_ovf    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({alu_a, alu_b, alu_op, alu_start, disp_value, disp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_hold outs a=%0d b=%0d op=%0d st=%0d d=%0d e=%0d busy=%0d exp all 0",
                     alu_a, alu_b, alu_op, alu_start, disp_value, disp_err, busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({alu_a, alu_b, alu_op, alu_start, disp_value, disp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_release outs nonzero d=%0d busy=%0d exp 0", disp_value, busy);
        end
    endtask

    task automatic test_basic_add();
        press(4'd1);
        press(4'd2);
        checks++;
        if (disp_value !== 16'd12) begin
            errors++; $display("FAIL add_dispA got %0d exp 12", disp_value);
        end
        press(KEY_ADD);
        press(4'd3);
        checks++;
        if (disp_value !== 16'd3) begin
            errors++; $display("FAIL add_dispB got %0d exp 3", disp_value);
        end
        nt = '{16'd12, 16'd3, OP_ADD, 16'd15};
        sb.push_back(nt);
        press(KEY_EQ);
        wait_start();
        et = sb.pop_front();
        checks++;
        if ({seen, ca, cb, cop} !== {1'b1, et.a, et.b, et.op}) begin
            errors++;
            $display("FAIL add_launch seen=%0d a=%0d b=%0d op=%0d exp a=%0d b=%0d op=%0d",
                     seen, ca, cb, cop, et.a, et.b, et.op);
        end
        tick();
        checks++;
        if ({alu_start, busy} !== 2'b01) begin
            errors++; $display("FAIL add_pulse start=%0d busy=%0d exp 0 1", alu_start, busy);
        end
        tick();
        tick();
        pulse_done(et.res, 1'b0);
        checks++;
        if ({disp_value, busy, disp_err} !== {et.res, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_result disp=%0d busy=%0d err=%0d exp %0d 0 0",
                     disp_value, busy, disp_err, et.res);
        end
    endtask

    task automatic test_chain();
`ifdef CALC_SEQ_CHAIN_EN
        press(KEY_SUB);
        checks++;
        if (disp_value !== 16'd15) begin
            errors++; $display("FAIL chain_dispA got %0d exp 15", disp_value);
        end
        press(4'd5);
        nt = '{16'd15, 16'd5, OP_SUB, 16'd10};
        sb.push_back(nt);
        press(KEY_EQ);
        wait_start();
        et = sb.pop_front();
        checks++;
        if ({seen, ca, cb, cop} !== {1'b1, et.a, et.b, et.op}) begin
            errors++;
            $display("FAIL chain_launch seen=%0d a=%0d b=%0d op=%0d exp a=%0d b=%0d op=%0d",
                     seen, ca, cb, cop, et.a, et.b, et.op);
        end
        tick();
        pulse_done(et.res, 1'b0);
        checks++;
        if (disp_value !== et.res) begin
            errors++; $display("FAIL chain_result got %0d exp %0d", disp_value, et.res);
        end
`else
        press(KEY_SUB);
        checks++;
        if ({disp_value, alu_op, busy} !== {16'd15, OP_ADD, 1'b0}) begin
            errors++;
            $display("FAIL chain_ignored disp=%0d op=%0d busy=%0d exp 15 0 0", disp_value, alu_op, busy);
        end
`endif
        press(KEY_CLR);
    endtask

    task automatic test_digit_limit();
        for (int d = 1; d <= 5; d++) press(4'(d));
        checks++;
        if ({disp_value, alu_a} !== {16'd1234, 16'd1234}) begin
            errors++; $display("FAIL limit_A disp=%0d a=%0d exp 1234", disp_value, alu_a);
        end
        press(KEY_SUB);
        press(KEY_MUL);
        press(KEY_EQ);
        checks++;
        if ({alu_op, busy, alu_start} !== {OP_MUL, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL limit_op op=%0d busy=%0d start=%0d exp 2 0 0", alu_op, busy, alu_start);
        end
        press(KEY_CLR);
        enable = 1'b0;
        press(4'd7);
        enable = 1'b1;
        checks++;
        if (disp_value !== 16'd0) begin
            errors++; $display("FAIL enable_drop disp=%0d exp 0", disp_value);
        end
    endtask

    task automatic test_timeout();
        press(4'd7);
        press(KEY_SUB);
        press(4'd2);
        nt = '{16'd7, 16'd2, OP_SUB, 16'd5};
        sb.push_back(nt);
        press(KEY_EQ);
        wait_start();
        et = sb.pop_front();
        checks++;
        if ({seen, ca, cb, cop} !== {1'b1, et.a, et.b, et.op}) begin
            errors++;
            $display("FAIL tmo_launch seen=%0d a=%0d b=%0d op=%0d exp a=%0d b=%0d op=%0d",
                     seen, ca, cb, cop, et.a, et.b, et.op);
        end
        tick();
        n = 0;
        while (!disp_err && n < 4 * TMO) begin
            tick();
            n++;
        end
        checks++;
        if ({n, disp_value, busy} !== {TMO, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL tmo_cycles n=%0d disp=%0d busy=%0d exp n=%0d disp=0 busy=0", n, disp_value, busy, TMO);
        end
        press(KEY_CLR);
        checks++;
        if ({alu_a, alu_b, alu_op, alu_start, disp_value, disp_err, busy} !== '0) begin
            errors++; $display("FAIL tmo_clear err=%0d disp=%0d exp 0 0", disp_err, disp_value);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) press(4'd9);
        press(KEY_MUL);
        for (int i = 0; i < 4; i++) press(4'd9);
        nt = '{16'd9999, 16'd9999, OP_MUL, 16'd0};
        sb.push_back(nt);
        press(KEY_EQ);
        wait_start();
        et = sb.pop_front();
        checks++;
        if ({seen, ca, cb, cop} !== {1'b1, et.a, et.b, et.op}) begin
            errors++;
            $display("FAIL ovf_launch seen=%0d a=%0d b=%0d op=%0d exp a=%0d b=%0d op=%0d",
                     seen, ca, cb, cop, et.a, et.b, et.op);
        end
        tick();
        pulse_done(16'h1234, 1'b1);
        press(4'd5);
        press(KEY_ADD);
        checks++;
        if ({disp_err, disp_value} !== {1'b1, 16'd0}) begin
            errors++; $display("FAIL ovf_error err=%0d disp=%0d exp 1 0", disp_err, disp_value);
        end
        press(KEY_CLR);
        checks++;
        if ({disp_err, disp_value, alu_a, alu_b} !== '0) begin
            errors++; $display("FAIL ovf_recover err=%0d disp=%0d exp 0 0", disp_err, disp_value);
        end
    endtask

    task automatic test_abort();
        press(4'd1);
        press(KEY_ADD);
        press(4'd2);
        press(KEY_EQ);
        tick();
        press(KEY_CLR);
        pulse_done(16'd99, 1'b0);
        checks++;
        if ({disp_value, busy} !== {16'd0, 1'b0}) begin
            errors++; $display("FAIL abort_clear disp=%0d busy=%0d exp 0 0", disp_value, busy);
        end
        // clear and alu_done on the same edge
        press(4'd3);
        press(KEY_ADD);
        press(4'd4);
        press(KEY_EQ);
        tick();
        alu_done   = 1'b1;
        alu_result = 16'd77;
        press(KEY_CLR);
        alu_done   = 1'b0;
        checks++;
        if ({disp_value, busy} !== {16'd0, 1'b0}) begin
            errors++; $display("FAIL abort_same_edge disp=%0d busy=%0d exp 0 0", disp_value, busy);
        end
        // asynchronous reset in WAIT
        press(4'd5);
        press(KEY_ADD);
        press(4'd6);
        press(KEY_EQ);
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, alu_start, disp_value, disp_err, busy} !== '0) begin
            errors++;
            $display("FAIL abort_async_reset a=%0d b=%0d busy=%0d exp all 0", alu_a, alu_b, busy);
        end
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (alu_start) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL abort_no_restart starts=%0d exp 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_chain();
        test_digit_limit();
        test_timeout();
        test_overflow();
        test_abort();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_left size=%0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
